// File: rtl/obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// obstacle_scheduler : draws one LFSR word per obstacle, counts the frame gap
//                      and offers the obstacle over a valid/ready handshake.
// Revision: 1.0
// ============================================================================
module obstacle_scheduler #(
  parameter int MIN_GAP_P   = 40,
  parameter int GAP_RANGE_W = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        frame_i,
  input  logic [1:0]  level_i,
  input  logic [15:0] rand_i,
  output logic        next_o,
  output logic        spawn_valid_o,
  input  logic        spawn_ready_i,
  output logic [1:0]  spawn_type_o,
  output logic [1:0]  spawn_height_o,
  output logic [7:0]  gap_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_OFFER = 2'd3;

  localparam logic [7:0] c_min_gap = 8'(MIN_GAP_P);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [7:0] r_cnt;
  logic [1:0] r_type;
  logic [1:0] r_height;

  logic [7:0] w_gap;
  logic [7:0] w_level_off;
  logic [7:0] w_rand_off;
  logic [1:0] w_type;
  logic [1:0] w_height;
  logic       w_unused_rand;

  assign w_level_off = {3'b000, level_i, 3'b000};
  assign w_rand_off  = 8'(rand_i[GAP_RANGE_W-1:0]);
  assign w_gap       = c_min_gap - w_level_off + w_rand_off;

  // Birds are suppressed at level 0; bird lane 3 folds back to lane 0.
  assign w_type   = (rand_i[15:14] == 2'd3 && level_i == 2'd0) ? 2'd0 : rand_i[15:14];
  assign w_height = (w_type == 2'd3 && rand_i[13:12] != 2'd3) ? rand_i[13:12] : 2'd0;

  assign w_unused_rand = ^rand_i[11:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!run_i) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_DRAW;
        S_DRAW:  w_next_state = S_COUNT;
        S_COUNT: if (frame_i && r_cnt == 8'd1) w_next_state = S_OFFER;
        S_OFFER: if (spawn_ready_i) w_next_state = S_DRAW;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      r_cnt    <= 8'd0;
      r_type   <= 2'd0;
      r_height <= 2'd0;
    end else begin
      case (r_state)
        S_DRAW: begin
          r_cnt    <= w_gap;
          r_type   <= w_type;
          r_height <= w_height;
        end
        S_COUNT: begin
          if (frame_i && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_o         = 1'b0;
    spawn_valid_o  = 1'b0;
    spawn_type_o   = 2'd0;
    spawn_height_o = 2'd0;
    gap_o          = 8'd0;
    case (r_state)
      S_DRAW:  next_o = run_i;
      S_COUNT: gap_o  = r_cnt;
      S_OFFER: begin
        spawn_valid_o  = 1'b1;
        spawn_type_o   = r_type;
        spawn_height_o = r_height;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_scheduler.sv
`default_nettype none
// ============================================================================
// tb_obstacle_scheduler : randomized bench for obstacle_scheduler against a
//                         transaction-level model of gap, type and height.
// Revision: 1.0
// ============================================================================
module tb_obstacle_scheduler;

  localparam int c_min_gap = 40;
  localparam int c_range_w = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        frame;
  logic [1:0]  level;
  logic [15:0] rnd;
  logic        next;
  logic        valid;
  logic        ready;
  logic [1:0]  stype;
  logic [1:0]  sheight;
  logic [7:0]  gap;

  int errors = 0;
  int checks = 0;
  int e_type;
  int e_height;
  int g;

  obstacle_scheduler #(
    .MIN_GAP_P   (c_min_gap),
    .GAP_RANGE_W (c_range_w)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .run_i          (run),
    .frame_i        (frame),
    .level_i        (level),
    .rand_i         (rnd),
    .next_o         (next),
    .spawn_valid_o  (valid),
    .spawn_ready_i  (ready),
    .spawn_type_o   (stype),
    .spawn_height_o (sheight),
    .gap_o          (gap)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic int model_gap(input int lvl, input logic [15:0] r);
    return c_min_gap - 8 * lvl + (int'(r) % (1 << c_range_w));
  endfunction

  function automatic int model_type(input int lvl, input logic [15:0] r);
    int t;
    t = int'(r) / 16384;
    if (t == 3 && lvl == 0) t = 0;
    return t;
  endfunction

  function automatic int model_height(input int t, input logic [15:0] r);
    int h;
    h = (int'(r) / 4096) % 4;
    return (t == 3 && h != 3) ? h : 0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_next"},   next,    0);
    check({tag, "_valid"},  valid,   0);
    check({tag, "_type"},   stype,   0);
    check({tag, "_height"}, sheight, 0);
    check({tag, "_gap"},    gap,     0);
  endtask

  // Entered during a DRAW cycle; returns during the first OFFER cycle.
  task automatic draw_and_count(input int lvl, input logic [15:0] rv, output int eg);
    int n;
    int cyc;
    level = 2'(lvl);
    rnd   = rv;
    frame = 1'($urandom_range(0, 1));
    settle();
    check("draw_next",  next,  1);
    check("draw_valid", valid, 0);
    eg       = model_gap(lvl, rv);
    e_type   = model_type(lvl, rv);
    e_height = model_height(e_type, rv);
    n   = 0;
    cyc = 0;
    step();
    while (n < eg && cyc < 3000) begin
      level = 2'($urandom_range(0, 3));
      rnd   = 16'($urandom);
      frame = ($urandom_range(0, 2) == 0);
      settle();
      check("count_gap",   gap,   eg - n);
      check("count_next",  next,  0);
      check("count_valid", valid, 0);
      check("count_type",  stype, 0);
      if (frame) n++;
      step();
      cyc++;
    end
    frame = 1'b0;
    if (n < eg) check("count_timeout", n, eg);
  endtask

  // Entered during the first OFFER cycle; returns during the next DRAW cycle.
  task automatic offer(input int hold);
    for (int i = 0; i < hold; i++) begin
      ready = 1'b0;
      frame = 1'($urandom_range(0, 1));
      rnd   = 16'($urandom);
      level = 2'($urandom_range(0, 3));
      settle();
      check("offer_valid",  valid,   1);
      check("offer_type",   stype,   e_type);
      check("offer_height", sheight, e_height);
      check("offer_next",   next,    0);
      check("offer_gap",    gap,     0);
      step();
    end
    ready = 1'b1;
    frame = 1'b0;
    settle();
    check("accept_valid",  valid,   1);
    check("accept_type",   stype,   e_type);
    check("accept_height", sheight, e_height);
    step();
    ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; frame = 1'b0; level = 2'd0; rnd = 16'd0; ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    settle();
    check_quiet("reset");
    step();
    run = 1'b1;
    settle();
    check_quiet("idle_run");
    step();

    draw_and_count(0, 16'h0001, g);
    offer(0);
    draw_and_count(2, 16'hE005, g);
    offer(10);
    draw_and_count(0, 16'hF03F, g);
    offer(3);
    for (int i = 0; i < 8; i++) begin
      draw_and_count(int'($urandom_range(0, 3)), 16'($urandom), g);
      offer(int'($urandom_range(0, 4)));
    end

    // run low during DRAW must suppress the LFSR step
    run = 1'b0;
    settle();
    check("drawdrop_next", next, 0);
    step();
    run = 1'b1;
    settle();
    check_quiet("drawdrop_idle");
    step();

    // run low mid-COUNT with 17 frames remaining
    level = 2'd3;
    rnd   = 16'h000E;
    frame = 1'b0;
    settle();
    check("drop_draw_next", next, 1);
    step();
    for (int i = 0; i < 13; i++) begin
      frame = 1'b1;
      settle();
      step();
    end
    frame = 1'b0;
    run   = 1'b0;
    settle();
    check("drop_gap",  gap,  17);
    check("drop_next", next, 0);
    step();
    settle();
    check_quiet("drop_after");
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet("drop_hold");
    end
    run = 1'b1;
    settle();
    check_quiet("rerun_idle");
    step();
    settle();
    check("rerun_next", next, 1);

    // reset while the obstacle is offered
    draw_and_count(1, 16'($urandom), g);
    ready = 1'b0;
    settle();
    check("prerst_valid", valid, 1);
    rst = 1'b1;
    step();
    settle();
    check_quiet("rst_offer");
    rst = 1'b0;
    step();
    settle();
    check("postrst_next", next, 1);
    draw_and_count(3, 16'($urandom), g);
    offer(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
